alu_share_arbiter: RTL and testbench

//  Shares the single combinational 32-bit ALU between two requesters:

---
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters (EX stage, aux unit) onto one combinational ALU and
// holds the result in a single response buffer tagged with the owning port.
//
// state    | meaning
// ST_EMPTY | response buffer free
// ST_FULL0 | buffer holds a result owned by port 0
// ST_FULL1 | buffer holds a result owned by port 1
module alu_share_arbiter #(
    parameter int RR_MODE      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic [4:0]  alu_flags,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_flags
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL0 = 2'b01,
        ST_FULL1 = 2'b10
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    logic        full, owner, can_accept;
    logic        gnt_vld, gnt;

    assign full       = (state_q != ST_EMPTY);
    assign owner      = (state_q == ST_FULL1);
    assign can_accept = !full || rsp_ready[owner];

    // Grant only targets a valid port, so a grant is always a fire.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
        if (can_accept) begin
            case (req_valid)
                2'b01: gnt_vld = 1'b1;
                2'b10: begin
                    gnt_vld = 1'b1;
                    gnt     = 1'b1;
                end
                2'b11: begin
                    gnt_vld = 1'b1;
                    gnt     = (RR_MODE != 0) ? !last_grant_q : (wait_cnt_q == LIMIT);
                end
                default: ;
            endcase
        end
    end

    assign req_ready = gnt_vld ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        alu_control = 4'b1111;
        alu_a       = 32'd0;
        alu_b       = 32'd0;
        if (gnt_vld) begin
            alu_control = gnt ? req1_op : req0_op;
            alu_a       = gnt ? req1_a  : req0_a;
            alu_b       = gnt ? req1_b  : req0_b;
        end
    end

    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        flags_d      = flags_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        if (gnt_vld) begin
            state_d      = gnt ? ST_FULL1 : ST_FULL0;
            result_d     = alu_result;
            flags_d      = alu_flags;
            last_grant_d = gnt;
        end else if (full && rsp_ready[owner]) begin
            state_d = ST_EMPTY;
        end
        // Starvation guard: only accept-eligible cycles lost by port 1 count.
        if (RR_MODE == 0) begin
            if (gnt_vld && gnt)
                wait_cnt_d = 4'd0;
            else if (req_valid[1] && can_accept && wait_cnt_q != LIMIT)
                wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            result_q     <= 32'd0;
            flags_q      <= 5'd0;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign rsp_valid  = state_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Drives a round-robin instance (index 0) and a fixed-priority instance (index 1)
// against a cycle-level reference model plus directed spot values.
module tb_alu_share_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid [2];
    logic [1:0]  req_ready [2];
    logic [3:0]  req_op [2][2];
    logic [31:0] req_a [2][2];
    logic [31:0] req_b [2][2];
    logic [3:0]  alu_control [2];
    logic [31:0] alu_a [2];
    logic [31:0] alu_b [2];
    logic [31:0] alu_result [2];
    logic [4:0]  alu_flags [2];
    logic [1:0]  rsp_valid [2];
    logic [1:0]  rsp_ready [2];
    logic [31:0] rsp_result [2];
    logic [4:0]  rsp_flags [2];

    int errors = 0;
    int checks = 0;

    // reference model state
    bit          m_full [2];
    bit          m_owner [2];
    logic [31:0] m_res [2];
    logic [4:0]  m_flg [2];
    bit          m_last [2];
    int          m_wait [2];
    logic [1:0]  got_ready [2];

    always #5 clk = ~clk;

    // ALU: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU, others 0
    function automatic logic [36:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic lt, ltu;
        lt  = $signed(a) < $signed(b);
        ltu = a < b;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = $signed(a) >>> b[4:0];
            4'd8: r = {31'd0, lt};
            4'd9: r = {31'd0, ltu};
            default: r = 32'd0;
        endcase
        return {a == b, lt, ltu, !lt, !ltu, r};
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++)
            {alu_flags[d], alu_result[d]} = alu_f(alu_control[d], alu_a[d], alu_b[d]);
    end

    alu_share_arbiter #(.RR_MODE(1), .STARVE_LIMIT(LIMIT)) u_rr (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req0_op(req_op[0][0]), .req0_a(req_a[0][0]), .req0_b(req_b[0][0]),
        .req1_op(req_op[0][1]), .req1_a(req_a[0][1]), .req1_b(req_b[0][1]),
        .alu_control(alu_control[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_result(alu_result[0]), .alu_flags(alu_flags[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_result(rsp_result[0]), .rsp_flags(rsp_flags[0])
    );

    alu_share_arbiter #(.RR_MODE(0), .STARVE_LIMIT(LIMIT)) u_fp (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req0_op(req_op[1][0]), .req0_a(req_a[1][0]), .req0_b(req_b[1][0]),
        .req1_op(req_op[1][1]), .req1_a(req_a[1][1]), .req1_b(req_b[1][1]),
        .alu_control(alu_control[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_result(alu_result[1]), .alu_flags(alu_flags[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_result(rsp_result[1]), .rsp_flags(rsp_flags[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 0; m_owner[d] = 0; m_res[d] = '0; m_flg[d] = '0;
            m_last[d] = 1; m_wait[d] = 0;
        end
    endtask

    // Which port should win this cycle: -1 none, else port number.
    function automatic int exp_grant(input int d);
        bit can;
        can = !m_full[d] || rsp_ready[d][m_owner[d]];
        if (!can || req_valid[d] == 2'b00) return -1;
        if (req_valid[d] == 2'b01) return 0;
        if (req_valid[d] == 2'b10) return 1;
        if (d == 0) return m_last[d] ? 0 : 1;
        return (m_wait[d] >= LIMIT) ? 1 : 0;
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        int g;
        bit can;
        logic [36:0] r;
        #1;
        for (int d = 0; d < 2; d++) begin
            g = exp_grant(d);
            can = !m_full[d] || rsp_ready[d][m_owner[d]];
            got_ready[d] = req_ready[d];
            chk($sformatf("ready[%0d]", d), 64'(req_ready[d]),
                g < 0 ? 64'd0 : (g == 1 ? 64'd2 : 64'd1));
            chk($sformatf("alu_ctl[%0d]", d), 64'(alu_control[d]),
                g < 0 ? 64'hF : 64'(req_op[d][g]));
            chk($sformatf("alu_a[%0d]", d), 64'(alu_a[d]), g < 0 ? 64'd0 : 64'(req_a[d][g]));
            chk($sformatf("alu_b[%0d]", d), 64'(alu_b[d]), g < 0 ? 64'd0 : 64'(req_b[d][g]));
            if (d == 1 && req_valid[d][1] && can && g != 1 && m_wait[d] < LIMIT)
                m_wait[d]++;
            if (g >= 0) begin
                r = alu_f(req_op[d][g], req_a[d][g], req_b[d][g]);
                m_flg[d] = r[36:32];
                m_res[d] = r[31:0];
                m_full[d] = 1;
                m_owner[d] = g[0];
                m_last[d] = g[0];
                if (g == 1) m_wait[d] = 0;
            end else if (m_full[d] && rsp_ready[d][m_owner[d]]) begin
                m_full[d] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rsp_valid[%0d]", d), 64'(rsp_valid[d]),
                !m_full[d] ? 64'd0 : (m_owner[d] ? 64'd2 : 64'd1));
            chk($sformatf("rsp_result[%0d]", d), 64'(rsp_result[d]), 64'(m_res[d]));
            chk($sformatf("rsp_flags[%0d]", d), 64'(rsp_flags[d]), 64'(m_flg[d]));
        end
        @(negedge clk);
    endtask

    task automatic set_port(input int d, input int p, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        req_op[d][p] = op; req_a[d][p] = a; req_b[d][p] = b;
    endtask

    initial begin
        logic [1:0] pat3 [6];
        logic [1:0] pat4 [6];
        pat3 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        pat4 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 2'b00; rsp_ready[d] = 2'b00; got_ready[d] = 2'b00;
            for (int p = 0; p < 2; p++) set_port(d, p, 4'd0, 32'd0, 32'd0);
        end
        model_reset();

        // reset state
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_valid", 64'(rsp_valid[d]), 64'd0);
            chk("reset_result", 64'(rsp_result[d]), 64'd0);
            chk("reset_flags", 64'(rsp_flags[d]), 64'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // 1: single ADD 7 + (-3)
        set_port(0, 0, 4'd0, 32'd7, -32'sd3);
        req_valid[0] = 2'b01; rsp_ready[0] = 2'b11;
        tick();
        chk("t1_ready", 64'(got_ready[0]), 64'd1);
        chk("t1_valid", 64'(rsp_valid[0]), 64'd1);
        chk("t1_result", 64'(rsp_result[0]), 64'd4);
        chk("t1_flags", 64'(rsp_flags[0]), 64'b00110);
        req_valid[0] = 2'b00;
        tick();

        // 2: backpressure on port 1 SLTU; port 0 waits, non-owner rsp_ready ignored
        set_port(0, 1, 4'd9, 32'hFFFF_FFFF, 32'd1);
        req_valid[0] = 2'b10; rsp_ready[0] = 2'b00;
        tick();
        set_port(0, 0, 4'd1, 32'd10, 32'd3);
        req_valid[0] = 2'b01; rsp_ready[0] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_ready", 64'(got_ready[0]), 64'd0);
            chk("t2_valid", 64'(rsp_valid[0]), 64'd2);
            chk("t2_result", 64'(rsp_result[0]), 64'd0);
            chk("t2_flags", 64'(rsp_flags[0]), 64'b01001);
        end
        req_valid[0] = 2'b00; rsp_ready[0] = 2'b10;
        tick();
        chk("t2_drain", 64'(rsp_valid[0]), 64'd0);

        // 3: round-robin contention
        rsp_ready[0] = 2'b11; req_valid[0] = 2'b11;
        for (int i = 0; i < 6; i++) begin
            set_port(0, 0, 4'(i), 32'(i * 17 + 5), 32'(i + 1));
            set_port(0, 1, 4'(i + 2), 32'(i * 31 + 9), 32'(i + 2));
            tick();
            chk($sformatf("t3_grant%0d", i), 64'(got_ready[0]), 64'(pat3[i]));
            chk($sformatf("t3_owner%0d", i), 64'(rsp_valid[0]), 64'(pat3[i]));
        end
        req_valid[0] = 2'b00;
        tick();

        // 4: starvation guard on the fixed-priority instance
        set_port(1, 0, 4'd0, 32'd100, 32'd1);
        set_port(1, 1, 4'd1, 32'd50, 32'd8);
        rsp_ready[1] = 2'b11; req_valid[1] = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("t4_grant%0d", i), 64'(got_ready[1]), 64'(pat4[i]));
        end
        req_valid[1] = 2'b00;
        tick();

        // 5: shifts and an undefined opcode
        rsp_ready[0] = 2'b11; req_valid[0] = 2'b01;
        set_port(0, 0, 4'd7, 32'h8000_0000, 32'd31);
        tick();
        chk("t5_sra", 64'(rsp_result[0]), 64'hFFFF_FFFF);
        set_port(0, 0, 4'd6, 32'h8000_0000, 32'd31);
        tick();
        chk("t5_srl", 64'(rsp_result[0]), 64'h1);
        set_port(0, 0, 4'b1100, 32'h1234_5678, 32'd3);
        tick();
        chk("t5_undef", 64'(rsp_result[0]), 64'h0);
        req_valid[0] = 2'b00;
        tick();

        // 6: asynchronous reset with a pending response
        set_port(0, 0, 4'd0, 32'd1, 32'd2);
        req_valid[0] = 2'b01; rsp_ready[0] = 2'b00;
        tick();
        chk("t6_pending", 64'(rsp_valid[0]), 64'd1);
        req_valid[0] = 2'b00;
        reset = 1'b1;
        #1;
        chk("t6_async", 64'(rsp_valid[0]), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        set_port(0, 1, 4'd3, 32'd4, 32'd8);
        req_valid[0] = 2'b11; rsp_ready[0] = 2'b11;
        tick();
        chk("t6_first", 64'(got_ready[0]), 64'd1);
        req_valid[0] = 2'b00;
        tick();

        // random traffic on both instances; pending requests keep their operands
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    if (req_valid[d][p] && !got_ready[d][p]) begin
                        req_valid[d][p] = ($urandom_range(0, 7) != 0);
                    end else begin
                        req_valid[d][p] = 1'($urandom_range(0, 1));
                        req_op[d][p] = 4'($urandom_range(0, 15));
                        req_a[d][p] = $urandom;
                        req_b[d][p] = ($urandom_range(0, 3) == 0) ? req_a[d][p] : $urandom;
                    end
                    rsp_ready[d][p] = ($urandom_range(0, 3) != 0);
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
